// File: rtl/booth_pkg.sv
// booth_pkg: shared widths and controller state encoding for the Booth host driver.
package booth_pkg;
  localparam int OP_W = 8;
  localparam int BUS_W = 9;
  localparam int PROD_W = 16;
  typedef enum logic [2:0] {IDLE, START, LOADM, WAIT, CAPLO, RESP} state_t;
endpackage

// File: rtl/booth_wdog_cnt.sv
// booth_wdog_cnt: clearable watchdog counter flagging its terminal count.
module booth_wdog_cnt #(
  parameter int CNT_W = 6,
  parameter int TC = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CNT_W'(TC);
endmodule

// File: rtl/booth_host_ctrl.sv
// booth_host_ctrl: sequences one Booth multiply per request and returns the reassembled product.
module booth_host_ctrl
  import booth_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   op_x,
  input  logic [OP_W-1:0]   op_m,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] product,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_inbus,
  input  logic              mul_final,
  input  logic [BUS_W-1:0]  mul_outbus
);
  state_t state, state_nx;
  logic [OP_W-1:0] op_m_q;
  logic [BUS_W-1:0] hi_q;
  logic wd_tc, a_bad, accept, timeout, unused;
  booth_wdog_cnt #(.CNT_W(CNT_W), .TC(TIMEOUT_CYC - 1)) u_wdog (
    .clk(clk), .reset(reset), .clr(state == LOADM), .en(state == WAIT), .tc(wd_tc)
  );
  assign req_ready = state == IDLE;
  assign accept = req_ready && req_valid;
  assign timeout = state == WAIT && !mul_final && wd_tc;
  assign a_bad = hi_q[8] ^ hi_q[7];
  // Q[-1] rides in the low bit of the Q word and carries no product information.
  assign unused = mul_outbus[0];
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = req_valid ? START : IDLE;
      START:   state_nx = LOADM;
      LOADM:   state_nx = WAIT;
      WAIT:    state_nx = mul_final ? CAPLO : wd_tc ? RESP : WAIT;
      CAPLO:   state_nx = RESP;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each lines up with the state it belongs to.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      op_m_q    <= '0;
      hi_q      <= '0;
      product   <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      mul_start <= 1'b0;
      mul_inbus <= '0;
    end else begin
      state     <= state_nx;
      mul_start <= state_nx == START;
      mul_inbus <= accept ? op_x : (state_nx == LOADM || state_nx == WAIT) ? op_m_q : '0;
      rsp_valid <= state_nx == RESP;
      if (accept) op_m_q <= op_m;
      if (state == WAIT && mul_final) hi_q <= mul_outbus;
      if (timeout) begin
        product <= '0;
        rsp_err <= 1'b1;
      end
      if (state == CAPLO) begin
        product <= a_bad ? '0 : {hi_q[OP_W-1:0], mul_outbus[BUS_W-1:1]};
        rsp_err <= a_bad;
      end
    end
endmodule

// File: tb/tb_booth_host_ctrl.sv
// tb_booth_host_ctrl: randomized bench acting as host and multiplier, checked against an arithmetic model.
module tb_booth_host_ctrl;
  logic clk = 0, reset = 0, req_valid = 0, rsp_ready = 0, mul_final = 0;
  logic [7:0] op_x = 0, op_m = 0;
  logic [8:0] mul_outbus = 0;
  logic req_ready, rsp_valid, rsp_err, mul_start;
  logic [15:0] product;
  logic [7:0] mul_inbus;
  int checks = 0, errors = 0;
  logic chk_en = 0, e_ready = 1, e_valid = 0, e_err = 0, e_start = 0;
  logic [7:0] e_inbus = 0;
  logic [15:0] e_prod = 0, got_prod;
  logic got_err;

  always #5 clk = ~clk;

  booth_host_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op_x(op_x), .op_m(op_m), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .product(product), .rsp_err(rsp_err), .mul_start(mul_start), .mul_inbus(mul_inbus),
    .mul_final(mul_final), .mul_outbus(mul_outbus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      check("mul_start", 32'(mul_start), 32'(e_start));
      check("mul_inbus", 32'(mul_inbus), 32'(e_inbus));
      if (e_valid) begin
        check("product", 32'(product), 32'(e_prod));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
      end
    end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_exp(input logic r, input logic v, input logic s, input logic [7:0] ib);
    e_ready = r; e_valid = v; e_start = s; e_inbus = ib;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      req_valid = 0; mul_final = 1'($urandom); mul_outbus = 9'($urandom);
      set_exp(1, 0, 0, 0);
      step();
    end
  endtask

  // nw: WAIT cycle carrying mul_final (0 = never); abort_at: WAIT cycle where reset pulses.
  task automatic txn(input logic [7:0] x, input logic [7:0] m, input int nw, input bit corrupt,
                     input int stall, input bit hold, input int abort_at);
    logic signed [15:0] p;
    logic [8:0] hi, lo;
    bit fin, resp;
    p = $signed(x) * $signed(m);
    hi = {p[15], p[15:8]};
    if (corrupt) hi[8] = ~hi[8];
    lo = {p[7:0], 1'($urandom)};
    req_valid = 1; op_x = x; op_m = m; mul_final = 1'($urandom);
    set_exp(0, 0, 1, x);
    step();
    req_valid = hold; op_x = 8'($urandom); op_m = 8'($urandom); mul_final = 1'($urandom);
    set_exp(0, 0, 0, m);
    step();
    mul_final = 1'($urandom);
    step();
    resp = 0;
    for (int k = 1; k <= 32 && !resp; k++) begin
      if (k == abort_at) begin
        reset = 0; mul_final = 0; req_valid = 0;
        set_exp(1, 0, 0, 0);
        step();
        check("abort_product", 32'(product), 32'h0);
        check("abort_err", 32'(rsp_err), 32'h0);
        reset = 1;
        step();
        return;
      end
      fin = nw != 0 && k == nw;
      mul_final = fin;
      mul_outbus = fin ? hi : 9'($urandom);
      if (fin) begin
        set_exp(0, 0, 0, 0);
        step();
        mul_outbus = lo; mul_final = 1'($urandom);
        set_exp(0, 1, 0, 0);
        e_err = corrupt; e_prod = corrupt ? 16'h0 : p;
        step();
        resp = 1;
      end else if (k == 32) begin
        set_exp(0, 1, 0, 0);
        e_err = 1; e_prod = 0;
        step();
        resp = 1;
      end else begin
        set_exp(0, 0, 0, m);
        step();
      end
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 0; mul_final = 1'($urandom); mul_outbus = 9'($urandom);
      step();
    end
    got_prod = product; got_err = rsp_err;
    rsp_ready = 1; req_valid = 0; mul_final = 0;
    set_exp(1, 0, 0, 0);
    step();
    rsp_ready = 0;
  endtask

  initial begin
    reset = 0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_product", 32'(product), 32'h0);
    check("rst_err", 32'(rsp_err), 32'h0);
    check("rst_start", 32'(mul_start), 32'h0);
    check("rst_inbus", 32'(mul_inbus), 32'h0);
    reset = 1;
    chk_en = 1;
    idle(2);
    txn(8'd7, 8'hFD, 4, 0, 0, 0, 0);
    check("t1_product", 32'(got_prod), 32'hFFEB);
    check("t1_err", 32'(got_err), 32'h0);
    idle(1);
    txn(8'h80, 8'h80, 7, 0, 0, 0, 0);
    check("t2_product", 32'(got_prod), 32'h4000);
    txn(8'd100, 8'd3, 2, 0, 5, 1, 0);
    check("t3_product", 32'(got_prod), 32'h012C);
    idle(2);
    txn(8'd9, 8'd9, 0, 0, 1, 0, 0);
    check("t4_product", 32'(got_prod), 32'h0);
    check("t4_err", 32'(got_err), 32'h1);
    idle(1);
    txn(8'd20, 8'd20, 10, 0, 0, 0, 3);
    txn(8'd3, 8'd5, 5, 0, 0, 0, 0);
    check("t5_product", 32'(got_prod), 32'h000F);
    idle(3);
    txn(8'h7F, 8'd2, 3, 1, 0, 0, 0);
    check("t6_product", 32'(got_prod), 32'h0);
    check("t6_err", 32'(got_err), 32'h1);
    idle(4);
    for (int i = 0; i < 40; i++) begin
      txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 32)), ($urandom % 8) == 0,
          int'($urandom_range(0, 3)), 1'($urandom), 0);
      idle(int'($urandom_range(0, 3)));
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
